// File: rtl/wv_loader.sv
// wv_loader: streams a block of weight words from a word-addressed memory
// with one-cycle read latency into a valid/ready stream. A two-entry output
// FIFO plus a single in-flight read flag give full throughput without ever
// overflowing, and each word is tagged with row-end and transfer-end flags.
module wv_loader #(
  parameter int unsigned WIDTH         = 64,
  parameter logic [31:0] WEIGHT_BASE   = 32'd0,
  parameter int unsigned WEIGHT_SIZE   = 32'd2048,
  parameter int unsigned WORDS_PER_ROW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_base_sel,
  input  logic [31:0]      start_addr,
  input  logic [15:0]      num_words,
  output logic             busy,
  output logic             done,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_row_last,
  output logic             m_last
);

  localparam logic [15:0] SIZE_MAX = 16'(WEIGHT_SIZE);
  localparam logic [15:0] ROW_END  = 16'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Control state
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic        rd_pending_q, rd_pending_d;

  // Capture-side counters used to tag words as they enter the FIFO
  logic [15:0] cap_cnt_q, cap_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;

  // Two-entry output FIFO
  logic [WIDTH-1:0] fifo_data_q [2];
  logic             fifo_row_last_q [2];
  logic             fifo_last_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;

  // Combinational helpers
  logic [15:0] eff_len_s;
  logic [31:0] base_s;
  logic        push_s;
  logic        pop_s;
  logic [2:0]  budget_s;
  logic        issue_ok_s;
  logic        issue_s;
  logic        head_last_s;
  logic        push_last_s;
  logic        push_row_last_s;

  assign eff_len_s   = (num_words > SIZE_MAX) ? SIZE_MAX : num_words;
  assign base_s      = start_base_sel ? start_addr : WEIGHT_BASE;
  assign push_s      = rd_pending_q;
  assign pop_s       = (occ_q != 2'd0) && m_ready;
  assign head_last_s = fifo_last_q[rd_ptr_q];

  // A new read may only go out if, after this cycle's capture and pop, at
  // most one entry is occupied; the read lands one cycle later, so the FIFO
  // can never hold more than two words.
  assign budget_s   = {1'b0, occ_q} + {2'b00, rd_pending_q} - {2'b00, pop_s};
  assign issue_ok_s = (budget_s <= 3'd1);

  assign push_last_s     = (cap_cnt_q == (len_q - 16'd1));
  assign push_row_last_s = (row_cnt_q == ROW_END);

  // FSM next state, address counter and read issue decision
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    issue_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = eff_len_s;
          issue_cnt_d = 16'd0;
          if (eff_len_s == 16'd0) begin
            // Zero-length request: no read, address stays where it was
            state_d = S_DONE;
          end else begin
            addr_d  = base_s;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (issue_ok_s) begin
          // The address currently on mem_addr is sampled by the memory now
          issue_s     = 1'b1;
          issue_cnt_d = issue_cnt_q + 16'd1;
          if (issue_cnt_q == (len_q - 16'd1)) begin
            // Last read: leave the address parked on it
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + 32'd1;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (pop_s && head_last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // In-flight read flag: data for an issued read appears one cycle later
  always_comb begin
    rd_pending_d = 1'b0;
    if (issue_s) begin
      rd_pending_d = 1'b1;
    end else begin
      rd_pending_d = 1'b0;
    end
  end

  // Capture-side word and row counters, restarted whenever idle
  always_comb begin
    cap_cnt_d = cap_cnt_q;
    row_cnt_d = row_cnt_q;
    if (state_q == S_IDLE) begin
      cap_cnt_d = 16'd0;
      row_cnt_d = 16'd0;
    end else if (push_s) begin
      cap_cnt_d = cap_cnt_q + 16'd1;
      if (push_row_last_s) begin
        row_cnt_d = 16'd0;
      end else begin
        row_cnt_d = row_cnt_q + 16'd1;
      end
    end else begin
      cap_cnt_d = cap_cnt_q;
      row_cnt_d = row_cnt_q;
    end
  end

  // FIFO occupancy next value
  always_comb begin
    occ_d = occ_q;
    if (push_s && !pop_s) begin
      occ_d = occ_q + 2'd1;
    end else if (!push_s && pop_s) begin
      occ_d = occ_q - 2'd1;
    end else begin
      occ_d = occ_q;
    end
  end

  // Control and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      len_q        <= 16'd0;
      issue_cnt_q  <= 16'd0;
      rd_pending_q <= 1'b0;
      cap_cnt_q    <= 16'd0;
      row_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      issue_cnt_q  <= issue_cnt_d;
      rd_pending_q <= rd_pending_d;
      cap_cnt_q    <= cap_cnt_d;
      row_cnt_q    <= row_cnt_d;
    end
  end

  // Output FIFO storage and pointers; reset discards buffered words
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]     <= {WIDTH{1'b0}};
        fifo_row_last_q[i] <= 1'b0;
        fifo_last_q[i]     <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q]     <= mem_data_out;
        fifo_row_last_q[wr_ptr_q] <= push_row_last_s;
        fifo_last_q[wr_ptr_q]     <= push_last_s;
        wr_ptr_q                  <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  // Outputs are decoded straight from registers
  assign busy         = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign mem_write_en = 1'b0;
  assign mem_addr     = addr_q;
  assign m_valid      = (occ_q != 2'd0);
  assign m_data       = fifo_data_q[rd_ptr_q];
  assign m_row_last   = m_valid && fifo_row_last_q[rd_ptr_q];
  assign m_last       = m_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_wv_loader.sv
// Directed bench for wv_loader: a one-cycle-latency memory returning its own
// address as data, directed transfers with hand-derived expectations.
module tb_wv_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_base_sel;
  logic [31:0] start_addr;
  logic [15:0] num_words;
  logic        busy;
  logic        done;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_data_out;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_row_last;
  logic        m_last;

  int n_cmp = 0;
  int n_err = 0;

  wv_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_base_sel (start_base_sel),
    .start_addr     (start_addr),
    .num_words      (num_words),
    .busy           (busy),
    .done           (done),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_row_last     (m_row_last),
    .m_last         (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: mem[i] = i, registered read
  always @(posedge clk) begin
    mem_data_out <= {32'h0000_0000, mem_addr};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ":busy"}, 64'(busy), 64'd0);
    check({tag, ":done"}, 64'(done), 64'd0);
    check({tag, ":m_valid"}, 64'(m_valid), 64'd0);
    check({tag, ":m_row_last"}, 64'(m_row_last), 64'd0);
    check({tag, ":m_last"}, 64'(m_last), 64'd0);
    check({tag, ":mem_we"}, 64'(mem_write_en), 64'd0);
  endtask

  // Runs one transfer starting at a negedge; returns at a negedge.
  task automatic run_xfer(input string tag, input logic sel, input logic [31:0] saddr,
                          input logic [15:0] nw, input int exp_n, input logic [31:0] exp_base,
                          input bit rand_ready, input int abort_after);
    int          c = 0;
    int          k = 0;
    int          hs_cycle = -1;
    int          done_cycle = -1;
    int          budget;
    bit          finished = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = 64'd0;
    logic        prev_row = 1'b0;
    logic        prev_last = 1'b0;
    logic [31:0] pre_addr;
    logic [31:0] nxt;
    logic        exp_done;

    budget   = exp_n * 8 + 40;
    pre_addr = mem_addr;
    start          = 1'b1;
    start_base_sel = sel;
    start_addr     = saddr;
    num_words      = nw;
    m_ready        = 1'b1;
    while (!finished) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        // start stays high one more cycle (must be ignored) and the
        // request fields change (must not matter after latching)
        num_words      = 16'hFFFF;
        start_addr     = ~saddr;
        start_base_sel = ~sel;
      end
      if (c == 2) start = 1'b0;

      if (abort_after >= 0 && k == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs({tag, ":in_rst"});
        check({tag, ":rst_m_data"}, m_data, 64'd0);
        check({tag, ":rst_mem_addr"}, 64'(mem_addr), 64'd0);
        rst = 1'b0;
        finished = 1'b1;
      end else begin
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        check({tag, ":mem_we"}, 64'(mem_write_en), 64'd0);

        if (exp_n > 0 && c == 1) check({tag, ":first_addr"}, 64'(mem_addr), 64'(exp_base));
        if (exp_n == 0) begin
          check({tag, ":zero_valid"}, 64'(m_valid), 64'd0);
          check({tag, ":zero_addr"}, 64'(mem_addr), 64'(pre_addr));
        end
        check({tag, ":busy"}, 64'(busy), 64'((exp_n > 0) && (k < exp_n)));
        if (exp_n == 0) exp_done = (c == 1);
        else exp_done = (hs_cycle >= 0) && (c == hs_cycle + 1);
        check({tag, ":done"}, 64'(done), 64'(exp_done));
        if (done) done_cycle = c;

        if (k < exp_n && busy) begin
          nxt = exp_base + 32'(k);
          check({tag, ":addr_ahead"}, 64'((mem_addr - nxt) <= 32'd2), 64'd1);
        end

        if (prev_stall) begin
          check({tag, ":valid_held"}, 64'(m_valid), 64'd1);
          check({tag, ":data_held"}, m_data, prev_data);
          check({tag, ":row_held"}, 64'(m_row_last), 64'(prev_row));
          check({tag, ":last_held"}, 64'(m_last), 64'(prev_last));
        end

        if (m_valid && m_ready) begin
          if (k < exp_n) begin
            nxt = exp_base + 32'(k);
            check({tag, ":data"}, m_data, {32'h0000_0000, nxt});
            check({tag, ":row_last"}, 64'(m_row_last), 64'((k % 16) == 15));
            check({tag, ":last"}, 64'(m_last), 64'(k == exp_n - 1));
            if (!rand_ready) check({tag, ":timing"}, 64'(c), 64'(3 + k));
            if (k == exp_n - 1) hs_cycle = c;
          end else begin
            check({tag, ":extra_word"}, 64'(k), 64'(exp_n - 1));
          end
          k++;
        end

        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_row   = m_row_last;
        prev_last  = m_last;

        if (done_cycle >= 0 && c >= done_cycle + 2) finished = 1'b1;
        if (!finished && c > budget) begin
          check({tag, ":timeout_done_seen"}, 64'(done_cycle >= 0), 64'd1);
          finished = 1'b1;
        end
      end
    end
    if (abort_after < 0) check({tag, ":count"}, 64'(k), 64'(exp_n));
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    start_base_sel = 1'b0;
    start_addr     = 32'd0;
    num_words      = 16'd0;
    m_ready        = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    num_words = 16'd5;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset:m_data", m_data, 64'd0);
    check("reset:mem_addr", 64'(mem_addr), 64'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    run_xfer("base32", 1'b0, 32'd0, 16'd32, 32, 32'd0, 1'b0, -1);
    run_xfer("rand5", 1'b1, 32'd100, 16'd5, 5, 32'd100, 1'b1, -1);
    run_xfer("zero", 1'b0, 32'd0, 16'd0, 0, 32'd0, 1'b0, -1);
    run_xfer("clamp", 1'b0, 32'd0, 16'd3000, 2048, 32'd0, 1'b0, -1);
    run_xfer("wrap", 1'b1, 32'hFFFF_FFFE, 16'd4, 4, 32'hFFFF_FFFE, 1'b0, -1);
    run_xfer("abort", 1'b0, 32'd0, 16'd32, 32, 32'd0, 1'b0, 7);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_abort:m_valid", 64'(m_valid), 64'd0);
    end
    run_xfer("restart", 1'b1, 32'd500, 16'd2, 2, 32'd500, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
